// File: rtl/cond_pipe_emw.sv
// cond_pipe_emw: execute-to-writeback tail of the pipelined ARM datapath.
// It evaluates the condition field against the carried flags and gates the
// architectural side effects (register write, memory write, PC redirect,
// branch, flag update). It produces the next flags value, then carries the
// surviving control and data through the EM and MW registers to the
// register-file write port.
//
// Build option: define COND_FULL_EN to decode the full ARM condition table.
// Without it, only EQ, NE and AL pass; every other code squashes the
// instruction.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset of EM/MW regs
//   PCSrcE..BranchE       E-stage control bits
//   FlagWriteE[1:0]       bit1 enables N,Z update; bit0 enables C,V update
//   CondE, FlagsE         condition field, current flags {N,Z,C,V}
//   ALUFlags              flags from this cycle's ALU op {N,Z,C,V}
//   ALUResultE, WriteDataE, WA3E   E-stage data and destination register
//   ReadDataM             data memory read data for the M-stage address
//   Flags, BranchTakenE, CondExE   combinational E-stage results
//   MemWriteM, ALUOutM, WriteDataM, WA3M           M-stage outputs
//   PCSrcW, RegWriteW, MemtoRegW, WA3W, ResultW    W-stage outputs
module cond_pipe_emw #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCSrcE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic             MemWriteE,
  input  logic             BranchE,
  input  logic [1:0]       FlagWriteE,
  input  logic [3:0]       CondE,
  input  logic [3:0]       FlagsE,
  input  logic [3:0]       ALUFlags,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic [WIDTH-1:0] WriteDataE,
  input  logic [3:0]       WA3E,
  input  logic [WIDTH-1:0] ReadDataM,
  output logic [3:0]       Flags,
  output logic             BranchTakenE,
  output logic             CondExE,
  output logic             MemWriteM,
  output logic [WIDTH-1:0] ALUOutM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [3:0]       WA3M,
  output logic             PCSrcW,
  output logic             RegWriteW,
  output logic             MemtoRegW,
  output logic [3:0]       WA3W,
  output logic [WIDTH-1:0] ResultW
);

  typedef enum logic [3:0] {
    condEQ = 4'h0, condNE = 4'h1, condCS = 4'h2, condCC = 4'h3,
    condMI = 4'h4, condPL = 4'h5, condVS = 4'h6, condVC = 4'h7,
    condHI = 4'h8, condLS = 4'h9, condGE = 4'hA, condLT = 4'hB,
    condGT = 4'hC, condLE = 4'hD, condAL = 4'hE, condNV = 4'hF
  } condCode_t;

  condCode_t cond;
  logic      zFlag;

  assign cond  = condCode_t'(CondE);
  assign zFlag = FlagsE[2];

`ifdef COND_FULL_EN
  logic nFlag, cFlag, vFlag;
  assign nFlag = FlagsE[3];
  assign cFlag = FlagsE[1];
  assign vFlag = FlagsE[0];

  always_comb begin
    CondExE = 1'b0;
    case (cond)
      condEQ: CondExE = zFlag;
      condNE: CondExE = ~zFlag;
      condCS: CondExE = cFlag;
      condCC: CondExE = ~cFlag;
      condMI: CondExE = nFlag;
      condPL: CondExE = ~nFlag;
      condVS: CondExE = vFlag;
      condVC: CondExE = ~vFlag;
      condHI: CondExE = cFlag & ~zFlag;
      condLS: CondExE = ~cFlag | zFlag;
      condGE: CondExE = (nFlag == vFlag);
      condLT: CondExE = (nFlag != vFlag);
      condGT: CondExE = ~zFlag & (nFlag == vFlag);
      condLE: CondExE = zFlag | (nFlag != vFlag);
      condAL: CondExE = 1'b1;
      default: CondExE = 1'b0;
    endcase
  end
`else
  always_comb begin
    CondExE = 1'b0;
    case (cond)
      condEQ: CondExE = zFlag;
      condNE: CondExE = ~zFlag;
      condAL: CondExE = 1'b1;
      default: CondExE = 1'b0;
    endcase
  end
`endif

  assign BranchTakenE = BranchE & CondExE;

  always_comb begin
    Flags = FlagsE;
    if (FlagWriteE[1] && CondExE) Flags[3:2] = ALUFlags[3:2];
    if (FlagWriteE[0] && CondExE) Flags[1:0] = ALUFlags[1:0];
  end

  // Execute/memory register: side-effect strobes are gated by the condition.
  logic PCSrcM, RegWriteM, MemtoRegM;

  always_ff @(posedge clk) begin
    if (reset) begin
      PCSrcM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WA3M       <= '0;
    end else begin
      PCSrcM     <= PCSrcE & CondExE;
      RegWriteM  <= RegWriteE & CondExE;
      MemWriteM  <= MemWriteE & CondExE;
      MemtoRegM  <= MemtoRegE;
      ALUOutM    <= ALUResultE;
      WriteDataM <= WriteDataE;
      WA3M       <= WA3E;
    end
  end

  // Memory/writeback register.
  logic [WIDTH-1:0] ReadDataW, ALUOutW;

  always_ff @(posedge clk) begin
    if (reset) begin
      PCSrcW    <= 1'b0;
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      ReadDataW <= '0;
      ALUOutW   <= '0;
      WA3W      <= '0;
    end else begin
      PCSrcW    <= PCSrcM;
      RegWriteW <= RegWriteM;
      MemtoRegW <= MemtoRegM;
      ReadDataW <= ReadDataM;
      ALUOutW   <= ALUOutM;
      WA3W      <= WA3M;
    end
  end

  assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

endmodule

// File: tb/tb_cond_pipe_emw.sv
module tb_cond_pipe_emw;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE;
  logic [1:0]       FlagWriteE;
  logic [3:0]       CondE, FlagsE, ALUFlags, WA3E;
  logic [WIDTH-1:0] ALUResultE, WriteDataE, ReadDataM;
  logic [3:0]       Flags;
  logic             BranchTakenE, CondExE, MemWriteM;
  logic [WIDTH-1:0] ALUOutM, WriteDataM, ResultW;
  logic [3:0]       WA3M, WA3W;
  logic             PCSrcW, RegWriteW, MemtoRegW;

  int checks = 0;
  int errors = 0;

  cond_pipe_emw #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .FlagWriteE(FlagWriteE),
    .CondE(CondE), .FlagsE(FlagsE), .ALUFlags(ALUFlags),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .WA3E(WA3E),
    .ReadDataM(ReadDataM), .Flags(Flags), .BranchTakenE(BranchTakenE),
    .CondExE(CondExE), .MemWriteM(MemWriteM), .ALUOutM(ALUOutM),
    .WriteDataM(WriteDataM), .WA3M(WA3M), .PCSrcW(PCSrcW),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .WA3W(WA3W),
    .ResultW(ResultW)
  );

  always #5 clk = ~clk;

  // Reference pipeline contents (what each stage should hold).
  logic             mPC = 0, mRW = 0, mMW = 0, mMR = 0;
  logic [WIDTH-1:0] mALU = 0, mWD = 0;
  logic [3:0]       mWA = 0;
  logic             wPC = 0, wRW = 0, wMR = 0;
  logic [WIDTH-1:0] wRD = 0, wALU = 0;
  logic [3:0]       wWA = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Condition pass, from the ARM rule: codes pair up as (predicate, inverse).
  function automatic logic condModel(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, p;
    {n, z, cy, v} = f;
`ifdef COND_FULL_EN
    case (c[3:1])
      3'd0: p = z;
      3'd1: p = cy;
      3'd2: p = n;
      3'd3: p = v;
      3'd4: p = cy & !z;
      3'd5: p = (n == v);
      3'd6: p = !z & (n == v);
      default: p = 1'b1;
    endcase
    return (c == 4'hF) ? 1'b0 : (p ^ c[0]);
`else
    if (c == 4'h0) return z;
    if (c == 4'h1) return !z;
    return (c == 4'hE);
`endif
  endfunction

  // Check the zero-latency outputs, clock once, then check the stage outputs.
  task automatic step();
    logic ce;
    logic [3:0] fl;
    logic             nPC, nRW, nMW, nMR;
    logic [WIDTH-1:0] nALU, nWD;
    logic [3:0]       nWA;
    #1;
    ce = condModel(CondE, FlagsE);
    fl = FlagsE;
    if (FlagWriteE[1] && ce) fl[3:2] = ALUFlags[3:2];
    if (FlagWriteE[0] && ce) fl[1:0] = ALUFlags[1:0];
    check("CondExE", CondExE, ce);
    check("BranchTakenE", BranchTakenE, BranchE & ce);
    check("Flags", Flags, fl);
    nPC = PCSrcE & ce; nRW = RegWriteE & ce; nMW = MemWriteE & ce;
    nMR = MemtoRegE; nALU = ALUResultE; nWD = WriteDataE; nWA = WA3E;
    @(posedge clk);
    if (reset) begin
      wPC = 0; wRW = 0; wMR = 0; wRD = 0; wALU = 0; wWA = 0;
      mPC = 0; mRW = 0; mMW = 0; mMR = 0; mALU = 0; mWD = 0; mWA = 0;
    end else begin
      wPC = mPC; wRW = mRW; wMR = mMR; wRD = ReadDataM; wALU = mALU; wWA = mWA;
      mPC = nPC; mRW = nRW; mMW = nMW; mMR = nMR; mALU = nALU; mWD = nWD; mWA = nWA;
    end
    #1;
    check("MemWriteM", MemWriteM, mMW);
    check("ALUOutM", ALUOutM, mALU);
    check("WriteDataM", WriteDataM, mWD);
    check("WA3M", WA3M, mWA);
    check("PCSrcW", PCSrcW, wPC);
    check("RegWriteW", RegWriteW, wRW);
    check("MemtoRegW", MemtoRegW, wMR);
    check("WA3W", WA3W, wWA);
    check("ResultW", ResultW, wMR ? wRD : wALU);
  endtask

  task automatic idle();
    PCSrcE = 0; RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0; BranchE = 0;
    FlagWriteE = 0; CondE = 4'hE; FlagsE = 0; ALUFlags = 0;
    ALUResultE = 0; WriteDataE = 0; WA3E = 0; ReadDataM = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    ALUResultE = 32'h1234_5678; WriteDataE = 32'hCAFE_0001; WA3E = 4'h9;
    RegWriteE = 1; MemWriteE = 1; ReadDataM = 32'h5555_AAAA;
    step();
    step();
    check("reset_MemWriteM", MemWriteM, 1'b0);
    check("reset_ResultW", ResultW, '0);
    check("reset_WA3W", WA3W, 4'h0);
    reset = 0;

    // AL add reaches writeback two cycles later.
    idle(); RegWriteE = 1; ALUResultE = 32'h5; WA3E = 4'd3;
    step();
    idle(); step();
    check("al_RegWriteW", RegWriteW, 1'b1);
    check("al_WA3W", WA3W, 4'd3);
    check("al_ResultW", ResultW, 32'h5);

    // EQ with Z clear squashes store and register write.
    idle(); CondE = 4'h0; MemWriteE = 1; RegWriteE = 1;
    step();
    check("eq_MemWriteM", MemWriteM, 1'b0);
    idle(); step();
    check("eq_RegWriteW", RegWriteW, 1'b0);

    // Partial flag updates.
    idle(); FlagWriteE = 2'b10; FlagsE = 4'b0011; ALUFlags = 4'b0100;
    #1 check("flags_nz", Flags, 4'b0111);
    step();
    idle(); FlagWriteE = 2'b01; FlagsE = 4'b0011; ALUFlags = 4'b0100;
    #1 check("flags_cv", Flags, 4'b0000);
    step();

    // Failed condition with full flag write leaves the flags untouched.
    idle(); CondE = 4'hF; FlagWriteE = 2'b11; FlagsE = 4'b1010; ALUFlags = 4'b0101;
    #1 check("flags_fail", Flags, 4'b1010);
    step();

    // Load path.
    idle(); MemtoRegE = 1; RegWriteE = 1; ALUResultE = 32'h40; WA3E = 4'd7;
    step();
    check("ld_ALUOutM", ALUOutM, 32'h40);
    idle(); ReadDataM = 32'hDEAD_BEEF;
    step();
    check("ld_ResultW", ResultW, 32'hDEAD_BEEF);

    // Branch GT, Z clear then Z set.
    idle(); CondE = 4'hC; FlagsE = 4'b1001; BranchE = 1; PCSrcE = 1;
    step();
    idle(); CondE = 4'hC; FlagsE = 4'b1101; BranchE = 1; PCSrcE = 1;
    step();
    idle(); step(); idle(); step();

    // Reset with a store sitting in M.
    idle(); MemWriteE = 1; RegWriteE = 1; ALUResultE = 32'h77;
    step();
    check("rst_pre_MemWriteM", MemWriteM, 1'b1);
    idle(); reset = 1;
    step();
    check("rst_MemWriteM", MemWriteM, 1'b0);
    check("rst_RegWriteW", RegWriteW, 1'b0);
    check("rst_ResultW", ResultW, '0);
    reset = 0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 39) == 0);
      PCSrcE     = 1'($urandom); RegWriteE = 1'($urandom);
      MemtoRegE  = 1'($urandom); MemWriteE = 1'($urandom);
      BranchE    = 1'($urandom); FlagWriteE = 2'($urandom);
      CondE      = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
      FlagsE     = 4'($urandom); ALUFlags = 4'($urandom);
      ALUResultE = $urandom; WriteDataE = $urandom;
      WA3E       = 4'($urandom); ReadDataM = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cond_pipe_emw.md
# cond_pipe_emw

Execute-to-writeback tail of the pipelined ARM datapath; consumes the E-stage control bundle produced by the decode/execute register. Evaluates the instruction's condition field against the carried flags and gates the architectural side effects: register write, memory write, PC redirect, branch and flag update. Computes the next flags value fed back to the decode/execute register. Carries the surviving control and data through the execute/memory and memory/writeback registers to the register-file write port.

## Interface
Parameters:
- WIDTH, 32, datapath width for ALU result, store data, read data and result.

Ports (clock and reset first):
- clk  input  1  pipeline clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clears every pipeline register.
- PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE  input  1 each  E-stage control bits.
- FlagWriteE  input  2  bit1 enables N,Z update; bit0 enables C,V update.
- CondE  input  4  ARM condition field.
- FlagsE  input  4  current flags {N,Z,C,V}.
- ALUFlags  input  4  flags from this cycle's ALU op {N,Z,C,V}.
- ALUResultE  input  WIDTH  ALU result.
- WriteDataE  input  WIDTH  store data.
- WA3E  input  4  destination register.
- ReadDataM  input  WIDTH  data memory read data for the M-stage address.
- Flags  output  4  next flags, combinational, to the decode/execute register.
- BranchTakenE  output  1  combinational, BranchE & CondExE.
- CondExE  output  1  combinational condition-pass.
- MemWriteM  output  1  gated store strobe.
- ALUOutM, WriteDataM  output  WIDTH  memory address / store data.
- WA3M  output  4  M-stage destination.
- PCSrcW, RegWriteW, MemtoRegW  output  1 each  W-stage control.
- WA3W  output  4  W-stage destination.
- ResultW  output  WIDTH  combinational, MemtoRegW ? ReadDataW : ALUOutW.

## Operation
- Condition decode (CondE → CondExE): 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F reserved → 0.
- Gating: PCSrc, RegWrite, MemWrite each ANDed with CondExE before entering EM register; MemtoReg, data and WA3 pass ungated.
- Flags: Flags[3:2] = (FlagWriteE[1] & CondExE) ? ALUFlags[3:2] : FlagsE[3:2]; Flags[1:0] likewise with FlagWriteE[0].
- EM register captures gated PCSrc, RegWrite, MemWrite, MemtoReg, ALUResultE, WriteDataE, WA3E.
- MW register captures PCSrcM, RegWriteM, MemtoRegM, ReadDataM, ALUOutM, WA3M.
- No stall/flush inputs; hazard control upstream flushes by zeroing the E-stage control bundle.

## Timing
- CondExE, BranchTakenE, Flags: same cycle as E inputs (zero latency).
- E→M: 1 cycle; E→W: 2 cycles; ResultW valid in the cycle WA3W/RegWriteW are valid.
- reset high at posedge: every EM and MW register → 0, so MemWriteM=0, ALUOutM=0, WriteDataM=0, WA3M=0, PCSrcW=0, RegWriteW=0, MemtoRegW=0, WA3W=0, ResultW=0 the following cycle; combinational outputs still follow inputs.
- Reset mid-operation: in-flight M and W instructions discarded, no partial writes after the reset edge.
- Back-to-back flag-setting instructions: Flags reflects only the current E instruction; ordering is maintained by the feedback loop through the decode/execute register.
- Failed condition with FlagWriteE=2'b11: Flags == FlagsE exactly.

## Configuration
- COND_FULL_EN defined: full condition table above.
- Undefined: only EQ (0), NE (1) and AL (E) decoded; all other codes yield CondExE=0 (instruction squashed, no flag update). Area-reduced build for the branch-only test core.

## Test plan
- AL add: CondE=E, RegWriteE=1, ALUResultE=0x0000_0005, WA3E=3 → two cycles later RegWriteW=1, WA3W=3, ResultW=0x5.
- EQ fail: FlagsE=4'b0000, CondE=0, MemWriteE=1, RegWriteE=1 → CondExE=0, MemWriteM=0 next cycle, RegWriteW=0 after two.
- Flag update: CondE=E, FlagWriteE=2'b10, FlagsE=4'b0011, ALUFlags=4'b0100 → Flags=4'b0111; FlagWriteE=2'b01 → Flags=4'b0000.
- Load path: MemtoRegE=1, RegWriteE=1, ALUResultE=0x40, ReadDataM=0xDEAD_BEEF on next cycle → ALUOutM=0x40, then ResultW=0xDEAD_BEEF.
- Branch GT with FlagsE N=1,V=1,Z=0, BranchE=1, PCSrcE=1 → BranchTakenE=1, PCSrcW=1 two cycles later; with Z=1 → both 0 (COND_FULL_EN only; without it CondExE=0 for both).
- Reset with store in M stage: MemWriteM=1, reset pulse → MemWriteM=0, RegWriteW=0, ResultW=0 next cycle.
